// File: rtl/roll_controller.sv
// Key-driven roll sequencer: debounces the count key, gates the counter while held,
// reduces the captured snapshot modulo RANGE bit-serially, then holds the display.
module roll_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SHOW_CYCLES     = 250_000_000,
  parameter int RANGE           = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_count,
  input  logic [31:0] counter_value,
  output logic        counter_enable,
  output logic [6:0]  count_value,
  output logic        display_enable,
  output logic        busy,
  output logic        roll_done
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_W = $clog2(SHOW_CYCLES + 1);
  localparam logic [7:0]      RANGE_B = 8'(RANGE);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_LOAD = TM_W'(SHOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ROLLING, REDUCE, SHOW} state_e;

  state_e            state_q, state_d;
  logic              key_meta_q, key_meta_d;
  logic              key_sync_q, key_sync_d;
  logic              key_db_q, key_db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [31:0]       snap_q, snap_d;
  logic [7:0]        rem_q, rem_d;
  logic [4:0]        idx_q, idx_d;
  logic [6:0]        count_q, count_d;
  logic [TM_W-1:0]   hold_q, hold_d;

  logic [7:0]        rem_sh, rem_nx;
  logic              last_bit;

  // Synchronizer and debounce: key_db follows key_sync only after a full run of disagreement.
  always_comb begin
    key_meta_d = key_count;
    key_sync_d = key_meta_q;
    key_db_d   = key_db_q;
    db_cnt_d   = '0;
    if (key_sync_q != key_db_q) begin
      if (db_cnt_q == DB_LAST) key_db_d = key_sync_q;
      else                     db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  assign last_bit = (state_q == REDUCE) && (idx_q == 5'd31);

  // Restoring step: rem stays below RANGE (<=127), so the shifted value fits 8 bits
  // and one conditional subtract keeps it reduced.
  assign rem_sh = {rem_q[6:0], snap_q[31]};
  assign rem_nx = (rem_sh >= RANGE_B) ? (rem_sh - RANGE_B) : rem_sh;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_db_q) state_d = ROLLING;
      ROLLING: if (!key_db_q) state_d = REDUCE;
      REDUCE:  if (last_bit) state_d = key_db_q ? ROLLING : SHOW;
      SHOW: begin
        if (key_db_q)            state_d = ROLLING;
        else if (hold_q == '0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    counter_enable = (state_q == ROLLING);
    busy           = (state_q == REDUCE);
    display_enable = (state_q == SHOW);
    roll_done      = last_bit;
    count_value    = count_q;
  end

  // Datapath: snapshot, serial reduction, result latch and display hold timer
  always_comb begin
    snap_d  = snap_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    count_d = count_q;
    hold_d  = hold_q;
    case (state_q)
      ROLLING: begin
        if (!key_db_q) begin
          snap_d = counter_value;
          rem_d  = '0;
          idx_d  = '0;
        end
      end
      REDUCE: begin
        snap_d = {snap_q[30:0], 1'b0};
        rem_d  = rem_nx;
        idx_d  = idx_q + 5'd1;
        if (last_bit) begin
          count_d = rem_nx[6:0];
          if (!key_db_q) hold_d = TM_LOAD;
        end
      end
      SHOW: begin
        if (hold_q != '0) hold_d = hold_q - TM_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta_q <= 1'b0;
      key_sync_q <= 1'b0;
      key_db_q   <= 1'b0;
      db_cnt_q   <= '0;
      snap_q     <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      hold_q     <= '0;
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      key_db_q   <= key_db_d;
      db_cnt_q   <= db_cnt_d;
      snap_q     <= snap_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_roll_controller.sv
// Directed bench for roll_controller with small debounce/show constants and a modelled counter.
module tb_roll_controller;
  localparam int DEB = 4;
  localparam int SHW = 20;
  localparam int RNG = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_count;
  logic [31:0] counter_value;
  logic        counter_enable;
  logic [6:0]  count_value;
  logic        display_enable;
  logic        busy;
  logic        roll_done;

  logic [31:0] cnt_m;
  logic        freeze;
  logic [31:0] frz_val;
  int          checks = 0;
  int          fails  = 0;

  roll_controller #(.DEBOUNCE_CYCLES(DEB), .SHOW_CYCLES(SHW), .RANGE(RNG)) dut (
    .clk(clk), .reset(reset), .key_count(key_count), .counter_value(counter_value),
    .counter_enable(counter_enable), .count_value(count_value),
    .display_enable(display_enable), .busy(busy), .roll_done(roll_done)
  );

  always #5 clk = ~clk;

  // Free-running counter model; freeze lets a test pin the value seen at the snapshot.
  always @(posedge clk or posedge reset) begin
    if (reset)               cnt_m <= '0;
    else if (counter_enable) cnt_m <= cnt_m + 32'd1;
  end
  assign counter_value = freeze ? frz_val : cnt_m;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ce(input logic v, output int n);
    n = 0;
    while (counter_enable !== v && n < 50) begin tick(); n++; end
    if (counter_enable !== v) n = -1;
  endtask

  task automatic run_reduce(output int nbusy, output int ndone, output int dpos, output int de_seen);
    nbusy = 0; ndone = 0; dpos = -1; de_seen = 0;
    while (busy === 1'b1 && nbusy < 40) begin
      nbusy++;
      if (roll_done === 1'b1) begin ndone++; dpos = nbusy; end
      if (display_enable === 1'b1) de_seen++;
      tick();
    end
  endtask

  task automatic wait_show(output int n);
    n = 0;
    while (display_enable === 1'b1 && n < 100) begin n++; tick(); end
  endtask

  // Press, hold, release with a pinned snapshot; returns at the first cycle after REDUCE.
  task automatic do_roll(input logic [31:0] snap, output int nbusy, output int ndone);
    int n, dpos, de;
    freeze = 1'b0; key_count = 1'b1;
    wait_ce(1'b1, n);
    repeat (3) tick();
    freeze = 1'b1; frz_val = snap; key_count = 1'b0;
    wait_ce(1'b0, n);
    run_reduce(nbusy, ndone, dpos, de);
  endtask

  task automatic test_reset();
    reset = 1'b1; key_count = 1'b0; freeze = 1'b0; frz_val = '0;
    tick(); tick();
    checks++; if (counter_enable !== 1'b0) begin fails++; $display("FAIL reset_ce: got %0b expected 0", counter_enable); end
    checks++; if (count_value !== 7'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count_value); end
    checks++; if (display_enable !== 1'b0) begin fails++; $display("FAIL reset_de: got %0b expected 0", display_enable); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (roll_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b expected 0", roll_done); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_roll_basic();
    int n, bad, nbusy, ndone, dpos, de;
    logic [31:0] c0;
    freeze = 1'b0; key_count = 1'b1;
    wait_ce(1'b1, n);
    checks++; if (n !== 7) begin fails++; $display("FAIL basic_ce_rise: got %0d cycles expected 7", n); end
    c0 = cnt_m; bad = 0;
    repeat (5) begin tick(); if (counter_enable !== 1'b1) bad++; end
    checks++; if (bad !== 0) begin fails++; $display("FAIL basic_ce_hold: got %0d low cycles expected 0", bad); end
    checks++; if (cnt_m - c0 !== 32'd5) begin fails++; $display("FAIL basic_count_incr: got %0d expected 5", cnt_m - c0); end
    freeze = 1'b1; frz_val = 32'd12345; key_count = 1'b0;
    wait_ce(1'b0, n);
    checks++; if (n !== 7) begin fails++; $display("FAIL basic_ce_fall: got %0d cycles expected 7", n); end
    run_reduce(nbusy, ndone, dpos, de);
    checks++; if (nbusy !== 32) begin fails++; $display("FAIL basic_busy_len: got %0d expected 32", nbusy); end
    checks++; if (ndone !== 1 || dpos !== 32) begin fails++; $display("FAIL basic_done_pulse: got %0d pulses at %0d expected 1 at 32", ndone, dpos); end
    checks++; if (count_value !== 7'd45) begin fails++; $display("FAIL basic_value: got %0d expected 45", count_value); end
    checks++; if (display_enable !== 1'b1 || roll_done !== 1'b0) begin fails++; $display("FAIL basic_show_entry: got de=%0b done=%0b expected de=1 done=0", display_enable, roll_done); end
    wait_show(n);
    checks++; if (n !== SHW) begin fails++; $display("FAIL basic_show_len: got %0d expected %0d", n, SHW); end
    checks++; if (count_value !== 7'd45 || counter_enable !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL basic_idle: got value=%0d ce=%0b busy=%0b expected 45/0/0", count_value, counter_enable, busy); end
  endtask

  task automatic test_modulo();
    logic [31:0] snaps [4] = '{32'hFFFF_FFFF, 32'd0, 32'd99, 32'd100};
    logic [6:0]  exps  [4] = '{7'd95, 7'd0, 7'd99, 7'd0};
    int nbusy, ndone, n;
    for (int i = 0; i < 4; i++) begin
      do_roll(snaps[i], nbusy, ndone);
      checks++; if (nbusy !== 32 || ndone !== 1) begin fails++; $display("FAIL mod_reduce_%0d: got busy=%0d done=%0d expected 32/1", i, nbusy, ndone); end
      checks++; if (count_value !== exps[i]) begin fails++; $display("FAIL mod_value_%0d: got %0d expected %0d", i, count_value, exps[i]); end
      wait_show(n);
    end
  endtask

  task automatic test_glitch();
    int ce_seen, done_seen;
    ce_seen = 0; done_seen = 0;
    key_count = 1'b1;
    repeat (3) begin tick(); ce_seen += int'(counter_enable); done_seen += int'(roll_done); end
    key_count = 1'b0;
    repeat (10) begin tick(); ce_seen += int'(counter_enable); done_seen += int'(roll_done); end
    for (int i = 0; i < 24; i++) begin
      key_count = ((i / 2) % 2) == 0;
      tick(); ce_seen += int'(counter_enable); done_seen += int'(roll_done);
    end
    key_count = 1'b0;
    repeat (10) begin tick(); ce_seen += int'(counter_enable); done_seen += int'(roll_done); end
    checks++; if (ce_seen !== 0) begin fails++; $display("FAIL glitch_ce: got %0d enabled cycles expected 0", ce_seen); end
    checks++; if (done_seen !== 0) begin fails++; $display("FAIL glitch_done: got %0d pulses expected 0", done_seen); end
    checks++; if (count_value !== 7'd0) begin fails++; $display("FAIL glitch_value: got %0d expected 0", count_value); end
  endtask

  task automatic test_repress_show();
    int n, nbusy, ndone, dpos, de;
    do_roll(32'd12345, nbusy, ndone);
    repeat (9) tick();
    checks++; if (display_enable !== 1'b1) begin fails++; $display("FAIL rshow_at10: got de=%0b expected 1", display_enable); end
    freeze = 1'b0; key_count = 1'b1;
    n = 0;
    while (display_enable === 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n !== 7) begin fails++; $display("FAIL rshow_de_drop: got %0d cycles expected 7", n); end
    checks++; if (counter_enable !== 1'b1) begin fails++; $display("FAIL rshow_ce_same_edge: got %0b expected 1", counter_enable); end
    checks++; if (count_value !== 7'd45) begin fails++; $display("FAIL rshow_value_held: got %0d expected 45", count_value); end
    repeat (3) tick();
    freeze = 1'b1; frz_val = 32'd250; key_count = 1'b0;
    wait_ce(1'b0, n);
    checks++; if (count_value !== 7'd45) begin fails++; $display("FAIL rshow_value_in_reduce: got %0d expected 45", count_value); end
    run_reduce(nbusy, ndone, dpos, de);
    checks++; if (ndone !== 1 || count_value !== 7'd50) begin fails++; $display("FAIL rshow_second: got done=%0d value=%0d expected 1/50", ndone, count_value); end
    wait_show(n);
  endtask

  task automatic test_repress_reduce();
    int n, nbusy, ndone, dpos, de;
    freeze = 1'b0; key_count = 1'b1;
    wait_ce(1'b1, n);
    repeat (3) tick();
    freeze = 1'b1; frz_val = 32'd12345; key_count = 1'b0;
    wait_ce(1'b0, n);
    key_count = 1'b1;
    run_reduce(nbusy, ndone, dpos, de);
    checks++; if (nbusy !== 32 || ndone !== 1) begin fails++; $display("FAIL rred_complete: got busy=%0d done=%0d expected 32/1", nbusy, ndone); end
    checks++; if (count_value !== 7'd45) begin fails++; $display("FAIL rred_value: got %0d expected 45", count_value); end
    checks++; if (display_enable !== 1'b0 || de !== 0 || counter_enable !== 1'b1) begin fails++; $display("FAIL rred_to_rolling: got de=%0b seen=%0d ce=%0b expected 0/0/1", display_enable, de, counter_enable); end
    repeat (2) tick();
    frz_val = 32'd345; key_count = 1'b0;
    wait_ce(1'b0, n);
    run_reduce(nbusy, ndone, dpos, de);
    checks++; if (count_value !== 7'd45 || display_enable !== 1'b1) begin fails++; $display("FAIL rred_second: got value=%0d de=%0b expected 45/1", count_value, display_enable); end
    wait_show(n);
  endtask

  task automatic test_reset_mid();
    int n, nbusy, ndone;
    freeze = 1'b0; key_count = 1'b1;
    wait_ce(1'b1, n);
    repeat (3) tick();
    freeze = 1'b1; frz_val = 32'd12345; key_count = 1'b0;
    wait_ce(1'b0, n);
    repeat (15) tick();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_pre_busy: got %0b expected 1", busy); end
    reset = 1'b1; #1;
    checks++; if (busy !== 1'b0 || counter_enable !== 1'b0 || display_enable !== 1'b0 || roll_done !== 1'b0)
      begin fails++; $display("FAIL rst_reduce_flags: got busy=%0b ce=%0b de=%0b done=%0b expected all 0", busy, counter_enable, display_enable, roll_done); end
    checks++; if (count_value !== 7'd0) begin fails++; $display("FAIL rst_reduce_value: got %0d expected 0", count_value); end
    tick(); reset = 1'b0; tick();
    do_roll(32'd12345, nbusy, ndone);
    repeat (5) tick();
    checks++; if (display_enable !== 1'b1 || count_value !== 7'd45) begin fails++; $display("FAIL rst_pre_show: got de=%0b value=%0d expected 1/45", display_enable, count_value); end
    reset = 1'b1; #1;
    checks++; if (display_enable !== 1'b0 || count_value !== 7'd0) begin fails++; $display("FAIL rst_show: got de=%0b value=%0d expected 0/0", display_enable, count_value); end
    tick(); reset = 1'b0; tick();
    do_roll(32'd777, nbusy, ndone);
    checks++; if (ndone !== 1 || count_value !== 7'd77) begin fails++; $display("FAIL rst_after_roll: got done=%0d value=%0d expected 1/77", ndone, count_value); end
    wait_show(n);
    checks++; if (n !== SHW) begin fails++; $display("FAIL rst_after_show: got %0d expected %0d", n, SHW); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_roll_basic();
    test_modulo();
    test_glitch();
    test_repress_show();
    test_repress_reduce();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/roll_controller.md
# roll_controller

Sequencer for the random-number datapath. Debounces the count key, gates the free-running counter while the key is held, and reduces the captured 32-bit counter snapshot modulo RANGE with a sequential restoring divider. It then holds the result on the display for a fixed time, and sits between the board keys and the counter, BCD and seven-segment path.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a key change (20 ms at 50 MHz); ≥1.
- SHOW_CYCLES, 250_000_000: display hold time in cycles (5 s); ≥1.
- RANGE, 100: result modulus; legal range 2..128.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- key_count  in  1  raw count key, active high (pressed = 1), asynchronous to clk.
- counter_value  in  32  free-running counter output.
- counter_enable  out  1  counter increment enable.
- count_value  out  7  last reduced result, 0..RANGE-1.
- display_enable  out  1  unblanks the seven-segment displays.
- busy  out  1  high while the modulo reduction runs.
- roll_done  out  1  one-cycle pulse when count_value updates.

## Operation
- Key path:
  - key_count passes through a 2-FF synchronizer to give key_sync.
  - The debounce counter clears whenever key_sync equals key_db.
  - key_db takes the value of key_sync on the DEBOUNCE_CYCLES-th consecutive cycle that they differ.
- States: IDLE, ROLLING, REDUCE, SHOW. The state register is Moore; outputs decode the state.
- IDLE:
  - Goes to ROLLING when key_db is 1.
- ROLLING:
  - counter_enable is 1.
  - When key_db is 0, snapshot counter_value into a 32-bit shift register, clear the 8-bit remainder and the bit index, then go to REDUCE.
- REDUCE:
  - busy is 1. Runs exactly 32 cycles, MSB first.
  - Each cycle: rem = {rem[6:0], snap[31]}; if rem ≥ RANGE then rem -= RANGE; shift snap left by one.
  - On the 32nd cycle, count_value <= rem[6:0] and roll_done pulses on that same cycle.
  - Next state is ROLLING if key_db = 1 at that point; otherwise SHOW.
  - key_db changes during REDUCE do not interrupt the reduction.
- SHOW:
  - display_enable is 1. A hold timer loads SHOW_CYCLES-1 on entry and decrements each cycle.
  - key_db = 1 → ROLLING. This takes priority over timer expiry.
  - Timer at 0 → IDLE.
- In IDLE and ROLLING the display is blanked; count_value keeps its last value.
- Width rules:
  - rem is 8 bits, so the shifted value is always < 256.
  - A 32-bit snapshot of 0xFFFFFFFF must reduce correctly.
  - count_value never reaches RANGE.

## Timing
- Reset value of every output is 0; state is IDLE; the synchronizer, debounce and hold counters are 0.
- Reset asserted mid-roll, mid-REDUCE or mid-SHOW forces the IDLE state at once, discards any partial remainder, and zeroes count_value.
- Key edge to key_db change: 2 + DEBOUNCE_CYCLES cycles.
- counter_enable changes 1 cycle after the corresponding key_db change.
- Snapshot is the counter_value present in the last ROLLING cycle. The counter still increments on that edge.
- REDUCE lasts 32 cycles. count_value and roll_done appear on the 32nd cycle after the snapshot edge.
- display_enable rises 1 cycle after roll_done and stays high exactly SHOW_CYCLES cycles unless the key is pressed again.
- A re-press during SHOW drops display_enable and raises counter_enable on the same edge, 1 cycle after key_db rises.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no state change.

## Test plan
Test parameters: DEBOUNCE_CYCLES=4, SHOW_CYCLES=20, RANGE=100. The bench models the counter.

1. Key held, counter snapshot 12345, key released:
   - counter_enable 1 during the hold.
   - busy for 32 cycles.
   - count_value=45 with a one-cycle roll_done.
   - display_enable 1 for exactly 20 cycles, then IDLE with count_value held at 45.
2. Snapshot 0xFFFFFFFF → count_value=95. Snapshot 0 → count_value=0. Snapshot 99 → 99. Snapshot 100 → 0.
3. key_count pulses high for 3 cycles, and separately chatters 1/0 every 2 cycles:
   - counter_enable stays 0.
   - No roll_done.
4. Key re-pressed at cycle 10 of SHOW:
   - display_enable drops and counter_enable rises on the same edge.
   - count_value unchanged until the next roll_done.
5. Key re-pressed and debounced during REDUCE:
   - Reduction completes with the correct value and roll_done.
   - Goes directly to ROLLING; display_enable never asserts.
6. Reset asserted at REDUCE cycle 16 and again mid-SHOW:
   - All outputs 0 asynchronously.
   - After release, a normal roll with snapshot 777 yields count_value=77.
